// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: shared 64-bit mtime with prescaler, per-hart msip and mtimecmp.
// Single-cycle peripheral port; every request is answered one cycle later with no back-pressure.
module clint_multi #(
    parameter int harts      = 1,
    parameter int clock_rate = 50000000,
    parameter int timer_rate = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clint_valid,
    input  logic             clint_instr,
    input  logic [31:0]      clint_addr,
    input  logic [31:0]      clint_wdata,
    input  logic [3:0]       clint_wstrb,
    output logic [31:0]      clint_rdata,
    output logic             clint_ready,
    output logic [63:0]      clint_mtime,
    output logic [harts-1:0] clint_msip,
    output logic [harts-1:0] clint_mtip
);

    localparam int div = clock_rate / timer_rate;
    localparam logic [31:0] div_last = 32'(div - 1);
    localparam logic [29:0] cmp_base_word = 30'd4096;
    localparam logic [29:0] mtime_lo_word = 30'd12286;
    localparam logic [29:0] mtime_hi_word = 30'd12287;

    if (div < 1 || harts < 1 || harts > 16) begin : g_bad_param
        $error("clint_multi: need clock_rate/timer_rate >= 1 and harts in 1..16");
    end

    // Handshake: a request is accepted on any edge where clint_valid=1 and reset=1;
    // clint_ready pulses for exactly the following cycle, with clint_rdata valid
    // only in that cycle (zero otherwise, for writes and for unmapped offsets).
    logic [31:0] pre_count;
    logic        tick;
    logic [29:0] word;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] rd_value;
    logic [63:0] mtimecmp [harts];
    logic        unused_ok;

    assign tick      = (pre_count == div_last);
    assign word      = clint_addr[31:2];
    assign wr_req    = clint_valid && (clint_wstrb != 4'b0000);
    assign rd_req    = clint_valid && (clint_wstrb == 4'b0000);
    assign unused_ok = &{1'b0, clint_instr, clint_addr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_word,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) result[8*i +: 8] = wdata[8*i +: 8];
        end
        return result;
    endfunction

    always_comb begin
        rd_value = 32'h0;
        for (int h = 0; h < harts; h++) begin
            if (word == 30'(h))
                rd_value = {31'h0, clint_msip[h]};
            if (word == cmp_base_word + 30'(2 * h))
                rd_value = mtimecmp[h][31:0];
            if (word == cmp_base_word + 30'(2 * h + 1))
                rd_value = mtimecmp[h][63:32];
        end
        if (word == mtime_lo_word) rd_value = clint_mtime[31:0];
        if (word == mtime_hi_word) rd_value = clint_mtime[63:32];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pre_count   <= 32'h0;
            clint_mtime <= 64'h0;
            clint_msip  <= '0;
            clint_mtip  <= '0;
            clint_ready <= 1'b0;
            clint_rdata <= 32'h0;
            for (int h = 0; h < harts; h++) mtimecmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            pre_count <= tick ? 32'h0 : pre_count + 32'h1;

            // A software write to mtime wins over the tick; the prescaler is untouched.
            if (wr_req && word == mtime_lo_word)
                clint_mtime[31:0] <= merge(clint_mtime[31:0], clint_wdata, clint_wstrb);
            else if (wr_req && word == mtime_hi_word)
                clint_mtime[63:32] <= merge(clint_mtime[63:32], clint_wdata, clint_wstrb);
            else if (tick)
                clint_mtime <= clint_mtime + 64'h1;

            for (int h = 0; h < harts; h++) begin
                if (wr_req && word == 30'(h) && clint_wstrb[0])
                    clint_msip[h] <= clint_wdata[0];
                if (wr_req && word == cmp_base_word + 30'(2 * h))
                    mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], clint_wdata, clint_wstrb);
                if (wr_req && word == cmp_base_word + 30'(2 * h + 1))
                    mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], clint_wdata, clint_wstrb);
                clint_mtip[h] <= (clint_mtime >= mtimecmp[h]);
            end

            clint_ready <= clint_valid;
            clint_rdata <= rd_req ? rd_value : 32'h0;
        end
    end

endmodule

// File: tb/tb_clint_multi.sv
// Bench for clint_multi with two harts and a divide-by-4 timer prescaler.
// Responses are scoreboarded; mtime is tracked by a small counter model.
module tb_clint_multi;

    logic        clock;
    logic        reset;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic [63:0] clint_mtime;
    logic [1:0]  clint_msip;
    logic [1:0]  clint_mtip;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // Reference: prescaler count, mtime and expected response strobe
    logic [1:0]  m_cnt;
    logic [63:0] m_mtime;
    logic        m_resp;

    clint_multi #(.harts(2), .clock_rate(8), .timer_rate(2)) dut (
        .clock(clock), .reset(reset),
        .clint_valid(clint_valid), .clint_instr(clint_instr),
        .clint_addr(clint_addr), .clint_wdata(clint_wdata), .clint_wstrb(clint_wstrb),
        .clint_rdata(clint_rdata), .clint_ready(clint_ready),
        .clint_mtime(clint_mtime), .clint_msip(clint_msip), .clint_mtip(clint_mtip)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        if (!reset) begin
            m_cnt   <= 2'd0;
            m_mtime <= 64'h0;
            m_resp  <= 1'b0;
        end else begin
            m_resp <= clint_valid;
            m_cnt  <= m_cnt + 2'd1;
            if (clint_valid && clint_wstrb == 4'hF && clint_addr == 32'd49144)
                m_mtime[31:0] <= clint_wdata;
            else if (clint_valid && clint_wstrb == 4'hF && clint_addr == 32'd49148)
                m_mtime[63:32] <= clint_wdata;
            else if (m_cnt == 2'd3)
                m_mtime <= m_mtime + 64'h1;
        end
    end

    always @(negedge clock) begin
        if (clint_ready || m_resp)
            check_eq("ready", clint_ready, m_resp);
        if (clint_ready) begin
            if (exp_q.size() == 0)
                check_eq("ready_spurious", clint_ready, 1'b0);
            else
                check_eq("rdata", clint_rdata, exp_q.pop_front());
        end else if (clint_rdata != 32'h0) begin
            check_eq("rdata_idle", clint_rdata, 32'h0);
        end
    end

    // Called at posedge+1; holds the request for exactly one edge.
    task automatic req(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp);
        clint_valid = 1'b1;
        clint_addr  = addr;
        clint_wdata = wdata;
        clint_wstrb = wstrb;
        exp_q.push_back(wstrb == 4'h0 ? exp : 32'h0);
        @(posedge clock); #1;
        clint_valid = 1'b0;
        clint_addr  = 32'h0;
        clint_wdata = 32'h0;
        clint_wstrb = 4'h0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        clint_valid = 1'b0;
        clint_instr = 1'b0;
        clint_addr  = 32'h0;
        clint_wdata = 32'h0;
        clint_wstrb = 4'h0;
        step(3);
        reset = 1'b1;

        // 1: reset state, prescaler rate, mtime read
        check_eq("rst_mtime", clint_mtime, 64'h0);
        check_eq("rst_msip", clint_msip, 2'b00);
        check_eq("rst_mtip", clint_mtip, 2'b00);
        check_eq("rst_ready", clint_ready, 1'b0);
        check_eq("rst_rdata", clint_rdata, 32'h0);
        step(12);
        check_eq("mtime_12cyc", clint_mtime, 64'd3);
        check_eq("mtip_idle", clint_mtip, 2'b00);
        req(32'd49144, 32'h0, 4'h0, 32'd3);
        req(32'd49148, 32'h0, 4'h0, 32'd0);

        // 2: software interrupts
        req(32'h4, 32'h1, 4'hF, 32'h0);
        check_eq("msip_set1", clint_msip, 2'b10);
        req(32'h0, 32'h0, 4'h0, 32'h0);
        req(32'h4, 32'h0, 4'h0, 32'h1);
        req(32'h4, 32'hFFFF_FFFE, 4'hF, 32'h0);
        check_eq("msip_clr1", clint_msip, 2'b00);

        // 3: timer compare on hart 0
        req(32'd49144, 32'h0, 4'hF, 32'h0);
        req(32'd16384, 32'd5, 4'hF, 32'h0);
        req(32'd16388, 32'd0, 4'hF, 32'h0);
        req(32'd16384, 32'h0, 4'h0, 32'd5);
        for (int i = 0; i < 100 && clint_mtime != 64'd5; i++) step(1);
        check_eq("mtime_reach5", clint_mtime, 64'd5);
        check_eq("mtip_lag", clint_mtip, 2'b00);
        step(1);
        check_eq("mtip0_rise", clint_mtip, 2'b01);

        // 4: carry into the high word, write in a tick cycle, read in a tick cycle
        req(32'd49148, 32'h0, 4'hF, 32'h0);
        req(32'd49144, 32'hFFFF_FFFF, 4'hF, 32'h0);
        for (int i = 0; i < 20 && clint_mtime[63:32] != 32'h1; i++) step(1);
        check_eq("mtime_carry", clint_mtime, 64'h1_0000_0000);
        for (int i = 0; i < 8 && m_cnt != 2'd3; i++) step(1);
        req(32'd49144, 32'h10, 4'hF, 32'h0);
        check_eq("tick_write", clint_mtime, 64'h1_0000_0010);
        step(3);
        check_eq("presc_run_a", clint_mtime, 64'h1_0000_0010);
        step(1);
        check_eq("presc_run_b", clint_mtime, 64'h1_0000_0011);
        for (int i = 0; i < 8 && m_cnt != 2'd3; i++) step(1);
        req(32'd49144, 32'h0, 4'h0, 32'h11);
        check_eq("tick_read_inc", clint_mtime, 64'h1_0000_0012);
        check_eq("model_mtime", clint_mtime, m_mtime);

        // 5: byte-lane write into mtimecmp[1] low word
        req(32'd16392, 32'h0000_AB00, 4'b0010, 32'h0);
        req(32'd16392, 32'h0, 4'h0, 32'hFFFF_ABFF);
        req(32'd16396, 32'h0, 4'h0, 32'hFFFF_FFFF);
        check_eq("mtip1_low", clint_mtip[1], 1'b0);

        // 6: unmapped offsets, then reset during a request
        req(32'h8, 32'h0, 4'h0, 32'h0);
        req(32'h2000, 32'h0, 4'h0, 32'h0);
        req(32'h8, 32'h1, 4'hF, 32'h0);
        check_eq("unmapped_wr", clint_msip, 2'b00);
        req(32'h0, 32'h1, 4'hF, 32'h0);
        check_eq("msip_set0", clint_msip, 2'b01);
        clint_valid = 1'b1;
        clint_addr  = 32'd49144;
        clint_wstrb = 4'h0;
        reset = 1'b0;
        step(1);
        clint_valid = 1'b0;
        clint_addr  = 32'h0;
        reset = 1'b1;
        check_eq("rst_drop_ready", clint_ready, 1'b0);
        check_eq("rst2_mtime", clint_mtime, 64'h0);
        check_eq("rst2_msip", clint_msip, 2'b00);
        check_eq("rst2_mtip", clint_mtip, 2'b00);
        check_eq("rst2_rdata", clint_rdata, 32'h0);
        req(32'd16384, 32'h0, 4'h0, 32'hFFFF_FFFF);
        req(32'd16388, 32'h0, 4'h0, 32'hFFFF_FFFF);
        req(32'd16392, 32'h0, 4'h0, 32'hFFFF_FFFF);
        check_eq("rst2_mtip_hold", clint_mtip, 2'b00);
        step(2);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
